// File: rtl/cache_arbiter_if.sv
// Memory-side bundle between the two caches, the arbiter and the cacheline adaptor.
// The arbiter takes the slave modport. The environment (caches plus adaptor) takes the master modport.
interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              ll_read;
    logic              ll_write;
    logic [ADDR_W-1:0] ll_address;
    logic [LINE_W-1:0] ll_wdata;
    logic [LINE_W-1:0] ll_rdata;
    logic              ll_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, ll_rdata, ll_resp,
        output i_rdata, i_resp, d_rdata, d_resp, ll_read, ll_write, ll_address, ll_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, ll_rdata, ll_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, ll_read, ll_write, ll_address, ll_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates the single cacheline memory port between the icache and the dcache.
// Define CACHE_ARB_RR_EN to get round-robin on conflict. The default is fixed dcache priority.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    cache_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;
    typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;

    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_t state, state_next;
    req_t   req;
    logic   last_grant;
    logic   i_req, d_req, any_req, grant_d;

    assign i_req   = bus.i_read;
    assign d_req   = bus.d_read | bus.d_write;
    assign any_req = i_req | d_req;

`ifdef CACHE_ARB_RR_EN
    assign grant_d = d_req & (~i_req | ~last_grant);
`else
    // last_grant is still tracked, but it cannot change the fixed-priority pick.
    assign grant_d = d_req | (d_req & last_grant);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The request is captured on grant, so the adaptor sees stable inputs even if the cache drops or changes its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            req        <= '0;
            last_grant <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_d;
            if (grant_d) begin
                req.op    <= bus.d_write ? OP_WRITE : OP_READ;
                req.addr  <= bus.d_address;
                req.wdata <= bus.d_wdata;
            end else begin
                req.op    <= OP_READ;
                req.addr  <= bus.i_address;
                req.wdata <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:             if (any_req) state_next = grant_d ? SERVE_D : SERVE_I;
            SERVE_I, SERVE_D: if (bus.ll_resp) state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ll_read    = 1'b0;
        bus.ll_write   = 1'b0;
        bus.i_resp     = 1'b0;
        bus.d_resp     = 1'b0;
        bus.ll_address = req.addr;
        bus.ll_wdata   = req.wdata;
        case (state)
            SERVE_I: begin
                bus.ll_read  = (req.op == OP_READ);
                bus.ll_write = (req.op == OP_WRITE);
                bus.i_resp   = bus.ll_resp;
            end
            SERVE_D: begin
                bus.ll_read  = (req.op == OP_READ);
                bus.ll_write = (req.op == OP_WRITE);
                bus.d_resp   = bus.ll_resp;
            end
            default: ;
        endcase
    end

    assign bus.i_rdata = bus.ll_rdata;
    assign bus.d_rdata = bus.ll_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: two requester processes, an adaptor model,
// and a transaction-level reference model whose expectations are checked by a negedge monitor.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;
    localparam int NREQ = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus();

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          op;     // 1 = write
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    typedef struct {
        logic          who;    // 1 = dcache
        logic [LW-1:0] data;
    } resp_t;

    int    checks = 0;
    int    passes = 0;
    txn_t  exp_ll[$];
    resp_t exp_resp[$];
    txn_t  cur;
    bit    m_busy = 1'b0, m_last = 1'b0, m_who = 1'b0;
    bit    prev_rst = 1'b1, prev_strobe = 1'b0;
    int    ad_cnt = -1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model and monitor. The inputs are stable here because the bench only drives them just after posedge.
    always @(negedge clk) begin : mon
        bit    busy0, freed, pick_d, ir, dr, strobe;
        txn_t  t;
        resp_t r;
        strobe = bus.ll_read | bus.ll_write;
        busy0  = m_busy;
        freed  = 1'b0;
        if (prev_rst) begin
            chk("rst_ll_read",  bus.ll_read,  1'b0);
            chk("rst_ll_write", bus.ll_write, 1'b0);
            chk("rst_i_resp",   bus.i_resp,   1'b0);
            chk("rst_d_resp",   bus.d_resp,   1'b0);
            chk("rst_ll_addr",  bus.ll_address, '0);
            chk("rst_ll_wdata", bus.ll_wdata, '0);
        end else begin
            if (m_busy && bus.ll_resp) begin
                r.who  = m_who;
                r.data = bus.ll_rdata;
                exp_resp.push_back(r);
                m_busy = 1'b0;
                freed  = 1'b1;
            end
            chk("strobe_active", strobe, busy0);
            if (strobe && !prev_strobe) begin
                chk("grant_queued", exp_ll.size(), 1);
                if (exp_ll.size() > 0) cur = exp_ll.pop_front();
            end
            if (strobe) begin
                chk("ll_write",   bus.ll_write,   cur.op);
                chk("ll_read",    bus.ll_read,    !cur.op);
                chk("ll_address", bus.ll_address, cur.addr);
                chk("ll_wdata",   bus.ll_wdata,   cur.wdata);
            end
            if (exp_resp.size() > 0) begin
                r = exp_resp.pop_front();
                chk("i_resp", bus.i_resp, r.who == 1'b0);
                chk("d_resp", bus.d_resp, r.who == 1'b1);
                chk("rdata", r.who ? bus.d_rdata : bus.i_rdata, r.data);
            end else begin
                chk("no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
            end
        end

        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b0;
            exp_ll.delete();
            exp_resp.delete();
        end else if (!m_busy && !freed) begin
            ir = bus.i_read;
            dr = bus.d_read | bus.d_write;
            if (ir || dr) begin
`ifdef CACHE_ARB_RR_EN
                pick_d = dr && (!ir || !m_last);
`else
                pick_d = dr;
`endif
                t.op    = pick_d && bus.d_write;
                t.addr  = pick_d ? bus.d_address : bus.i_address;
                t.wdata = pick_d ? bus.d_wdata : '0;
                exp_ll.push_back(t);
                m_who  = pick_d;
                m_last = pick_d;
                m_busy = 1'b1;
            end
        end
        prev_rst    = rst;
        prev_strobe = strobe;
    end

    // Adaptor: completes each strobe after 0-8 cycles, and sometimes fires a stray ll_resp while idle.
    initial begin
        bus.ll_resp  = 1'b0;
        bus.ll_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.ll_resp = 1'b0;
            if (rst) ad_cnt = -1;
            else if (bus.ll_read | bus.ll_write) begin
                if (ad_cnt < 0) ad_cnt = $urandom_range(0, 8);
                if (ad_cnt == 0) begin
                    bus.ll_resp  = 1'b1;
                    bus.ll_rdata = rand_line();
                    ad_cnt = -1;
                end else ad_cnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.ll_resp  = 1'b1;
                bus.ll_rdata = rand_line();
            end
        end
    end

    task automatic run_icache();
        for (int n = 0; n < NREQ; n++) begin
            bit got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clk);
                got = bus.i_resp;
                if (!got) begin @(posedge clk); #1; end
            end
            chk("i_resp_timeout", got, 1'b1);
            if (!got) return;
            @(posedge clk); #1;
            if (n == NREQ-1) begin
                bus.i_read = 1'b0;
            end else begin
                if (n == 0 || (n > 1 && $urandom_range(0, 1) == 1)) begin
                    bus.i_read = 1'b0;
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                end
                bus.i_address = (n == 0) ? 32'h60 : (n == 1) ? 32'h20 : ($urandom & ~32'h1f);
                bus.i_read    = 1'b1;
            end
        end
    endtask

    task automatic run_dcache();
        for (int n = 0; n < NREQ; n++) begin
            bit got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clk);
                got = bus.d_resp;
                if (!got) begin
                    @(posedge clk); #1;
                    if (n == 1 && w == 2) bus.d_address = 32'h80;
                    else if ($urandom_range(0, 9) == 0) begin
                        bus.d_address = $urandom & ~32'h1f;
                        bus.d_wdata   = rand_line();
                    end
                end
            end
            chk("d_resp_timeout", got, 1'b1);
            if (!got) return;
            @(posedge clk); #1;
            if (n == NREQ-1) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.d_read  = 1'b0;
                    bus.d_write = 1'b0;
                    repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
                end
                bus.d_write   = ($urandom_range(0, 1) == 1);
                bus.d_read    = !bus.d_write || ($urandom_range(0, 7) == 0);
                bus.d_address = (n == 0) ? 32'h40 : ($urandom & ~32'h1f);
                bus.d_wdata   = rand_line();
            end
        end
    endtask

    initial begin
        bus.i_read    = 1'b1;
        bus.i_address = 32'h100;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h2000;
        bus.d_wdata   = {32{8'hA5}};
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        fork
            run_icache();
            run_dcache();
        join
        repeat (20) @(posedge clk);
        #1;
        chk("drain_grants", exp_ll.size(), 0);
        chk("drain_resps",  exp_resp.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
